// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage: ALU operation codes, default widths
// and the control bundle together with its bubble encoding.
package id_ex_stage_pkg;

  localparam int DEFAULT_DATA_WIDTH     = 32;
  localparam int DEFAULT_REG_ADDR_WIDTH = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b1000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SRA  = 4'b1101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111
  } alu_op_e;

  // Control bits carried through the ID/EX register.
  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [3:0] alu_sel;
    logic       alu_src_a;
    logic       alu_src_b;
  } ctrl_t;

  // A bubble has no side effects and selects add on register operands.
  localparam ctrl_t CTRL_BUBBLE = '{
    valid:     1'b0,
    reg_write: 1'b0,
    mem_read:  1'b0,
    mem_write: 1'b0,
    alu_sel:   ALU_ADD,
    alu_src_a: 1'b0,
    alu_src_b: 1'b0
  };

endpackage

// File: rtl/id_ex_stage_fwd_unit.sv
// Operand forwarding for one source register: the EX/MEM result has priority
// over MEM/WB, and x0 is never forwarded.
module fwd_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] rs,
  input  logic                      mem_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] mem_rd,
  input  logic [DATA_WIDTH-1:0]     mem_data,
  input  logic                      wb_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
  input  logic [DATA_WIDTH-1:0]     wb_data,
  input  logic [DATA_WIDTH-1:0]     reg_value,
  output logic [DATA_WIDTH-1:0]     fwd_value
);

  // Pick the youngest in-flight producer of rs, else the registered value.
  always_comb begin
    fwd_value = reg_value;
    if (mem_reg_write && (mem_rd != '0) && (mem_rd == rs)) begin
      fwd_value = mem_data;
    end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rs)) begin
      fwd_value = wb_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-side forwarding, ALU source selection and
// load-use hazard detection (bubble inserted here, IF/ID stalled upstream).
import id_ex_stage_pkg::*;

module id_ex_stage #(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = DEFAULT_REG_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      Stall,
  input  logic                      Flush,
  input  logic                      ID_Valid,
  input  logic [DATA_WIDTH-1:0]     ID_PC,
  input  logic [DATA_WIDTH-1:0]     ID_RD1,
  input  logic [DATA_WIDTH-1:0]     ID_RD2,
  input  logic [DATA_WIDTH-1:0]     ID_Imm,
  input  logic [REG_ADDR_WIDTH-1:0] ID_Rs1,
  input  logic [REG_ADDR_WIDTH-1:0] ID_Rs2,
  input  logic [REG_ADDR_WIDTH-1:0] ID_Rd,
  input  logic [3:0]                ID_ALUSel,
  input  logic                      ID_ALUSrcA,
  input  logic                      ID_ALUSrcB,
  input  logic                      ID_RegWrite,
  input  logic                      ID_MemRead,
  input  logic                      ID_MemWrite,
  input  logic                      MEM_RegWrite,
  input  logic [REG_ADDR_WIDTH-1:0] MEM_Rd,
  input  logic [DATA_WIDTH-1:0]     MEM_Data,
  input  logic                      WB_RegWrite,
  input  logic [REG_ADDR_WIDTH-1:0] WB_Rd,
  input  logic [DATA_WIDTH-1:0]     WB_Data,
  output logic [DATA_WIDTH-1:0]     Src_A,
  output logic [DATA_WIDTH-1:0]     Src_B,
  output logic [3:0]                ALUSel,
  output logic [DATA_WIDTH-1:0]     EX_Store_Data,
  output logic [REG_ADDR_WIDTH-1:0] EX_Rd,
  output logic                      EX_RegWrite,
  output logic                      EX_MemRead,
  output logic                      EX_MemWrite,
  output logic                      EX_Valid,
  output logic                      Load_Use_Hazard
);

  ctrl_t                     ctrl_q;
  logic [REG_ADDR_WIDTH-1:0] rd_q, rs1_q, rs2_q;
  logic [DATA_WIDTH-1:0]     pc_q, rd1_q, rd2_q, imm_q;
  logic [DATA_WIDTH-1:0]     fwd_a, fwd_b;

  // Pipeline register: reset/flush bubble, stall hold, load-use bubble, capture.
  always_ff @(posedge clk) begin
    if (rst || Flush || (!Stall && Load_Use_Hazard)) begin
      ctrl_q <= CTRL_BUBBLE;
      rd_q   <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      pc_q   <= '0;
      rd1_q  <= '0;
      rd2_q  <= '0;
      imm_q  <= '0;
    end else if (!Stall) begin
      ctrl_q <= '{
        valid:     ID_Valid,
        reg_write: ID_RegWrite,
        mem_read:  ID_MemRead,
        mem_write: ID_MemWrite,
        alu_sel:   ID_ALUSel,
        alu_src_a: ID_ALUSrcA,
        alu_src_b: ID_ALUSrcB
      };
      rd_q   <= ID_Rd;
      rs1_q  <= ID_Rs1;
      rs2_q  <= ID_Rs2;
      pc_q   <= ID_PC;
      rd1_q  <= ID_RD1;
      rd2_q  <= ID_RD2;
      imm_q  <= ID_Imm;
    end
  end

  fwd_unit #(
    .DATA_WIDTH     (DATA_WIDTH),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_fwd_a (
    .rs            (rs1_q),
    .mem_reg_write (MEM_RegWrite),
    .mem_rd        (MEM_Rd),
    .mem_data      (MEM_Data),
    .wb_reg_write  (WB_RegWrite),
    .wb_rd         (WB_Rd),
    .wb_data       (WB_Data),
    .reg_value     (rd1_q),
    .fwd_value     (fwd_a)
  );

  fwd_unit #(
    .DATA_WIDTH     (DATA_WIDTH),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_fwd_b (
    .rs            (rs2_q),
    .mem_reg_write (MEM_RegWrite),
    .mem_rd        (MEM_Rd),
    .mem_data      (MEM_Data),
    .wb_reg_write  (WB_RegWrite),
    .wb_rd         (WB_Rd),
    .wb_data       (WB_Data),
    .reg_value     (rd2_q),
    .fwd_value     (fwd_b)
  );

  // ALU operand selection and registered control outputs.
  always_comb begin
    Src_A         = ctrl_q.alu_src_a ? pc_q : fwd_a;
    Src_B         = ctrl_q.alu_src_b ? imm_q : fwd_b;
    EX_Store_Data = fwd_b;
    ALUSel        = ctrl_q.alu_sel;
    EX_Rd         = rd_q;
    EX_RegWrite   = ctrl_q.reg_write;
    EX_MemRead    = ctrl_q.mem_read;
    EX_MemWrite   = ctrl_q.mem_write;
    EX_Valid      = ctrl_q.valid;
  end

  // Conservative load-use detection: matches rs2 even if ID does not read it.
  always_comb begin
    Load_Use_Hazard = ctrl_q.valid && ctrl_q.mem_read && (rd_q != '0) && ID_Valid &&
                      ((rd_q == ID_Rs1) || (rd_q == ID_Rs2));
  end

endmodule
